// File: rtl/ibuf_credit_ctrl.sv
// Credit-based flow controller between fetch/predecode and the instruction buffer.
// Credits count free buffer entries minus entries reserved for packets still in
// the predecode pipeline, so a grant always has a full FETCH_WIDTH slot waiting.
//
// Ports:
//   clk, rst      clock, asynchronous active-high reset
//   fetch_req     fetch stage has a packet to launch
//   fetch_grant   packet may launch this cycle (combinational), reserves FETCH_WIDTH credits
//   enq_valid     packet written into the buffer this cycle
//   enq_num       valid instructions in that packet (0..FETCH_WIDTH)
//   deq_num       entries consumed by decode this cycle
//   redirect      frontend redirect; buffer cleared this cycle
//   credits       free, unreserved entries
//   inflight      granted packets not yet enqueued
//   flush_busy    flush in progress; enqueued packets are stale
//   err_overflow  sticky protocol error
module ibuf_credit_ctrl #(
  parameter int unsigned IBUF_SIZE   = 16,
  parameter int unsigned FETCH_WIDTH = 4,
  parameter int unsigned PIPE_DEPTH  = 2
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            fetch_req,
  output logic                            fetch_grant,
  input  logic                            enq_valid,
  input  logic [$clog2(FETCH_WIDTH):0]    enq_num,
  input  logic [$clog2(FETCH_WIDTH):0]    deq_num,
  input  logic                            redirect,
  output logic [$clog2(IBUF_SIZE):0]      credits,
  output logic [$clog2(PIPE_DEPTH):0]     inflight,
  output logic                            flush_busy,
  output logic                            err_overflow
);

  localparam int unsigned CW = $clog2(IBUF_SIZE) + 1;
  localparam int unsigned NW = $clog2(FETCH_WIDTH) + 1;
  localparam int unsigned IW = $clog2(PIPE_DEPTH) + 1;
  localparam int unsigned SW = CW + 1;

  typedef enum logic {
    S_RUN,
    S_FLUSH
  } state_t;

  state_t          state;
  logic [IW-1:0]   flush_cnt;

  logic [IW-1:0]   inflight_eff;
  logic [IW-1:0]   inflight_next;
  logic [SW-1:0]   refund;
  logic [SW-1:0]   credit_sum;
  logic            sum_over;
  logic            enq_orphan;
  logic            enq_bad_num;

  // An enqueue with nothing in flight cannot retire a packet; inflight floors at 0.
  assign inflight_eff = (enq_valid && (inflight != '0)) ? inflight - IW'(1) : inflight;

  // Grant only on registered credits, so freed entries show up one cycle later.
  assign fetch_grant = !rst && fetch_req && (state == S_RUN) && !redirect &&
                       (credits >= CW'(FETCH_WIDTH)) &&
                       (inflight_eff < IW'(PIPE_DEPTH));

  // A short packet returns the unused part of its FETCH_WIDTH reservation.
  assign refund = (enq_valid && (enq_num <= NW'(FETCH_WIDTH)))
                  ? SW'(FETCH_WIDTH) - SW'(enq_num) : '0;

  // Guard bit keeps the sum exact so an overshoot past IBUF_SIZE is detectable.
  assign credit_sum = SW'(credits) + refund + SW'(deq_num)
                      - (fetch_grant ? SW'(FETCH_WIDTH) : '0);

  assign sum_over      = credit_sum > SW'(IBUF_SIZE);
  assign enq_orphan    = enq_valid && (inflight == '0);
  assign enq_bad_num   = enq_valid && (enq_num > NW'(FETCH_WIDTH));
  assign inflight_next = inflight_eff + IW'(fetch_grant);

  // Control FSM with credit/inflight bookkeeping; redirect wins in every state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= S_RUN;
      flush_cnt    <= '0;
      credits      <= CW'(IBUF_SIZE);
      inflight     <= '0;
      flush_busy   <= 1'b0;
      err_overflow <= 1'b0;
    end else if (redirect) begin
      state      <= S_FLUSH;
      flush_cnt  <= IW'(PIPE_DEPTH);
      credits    <= CW'(IBUF_SIZE);
      inflight   <= '0;
      flush_busy <= 1'b1;
    end else begin
      case (state)
        S_RUN: begin
          credits  <= sum_over ? CW'(IBUF_SIZE) : credit_sum[CW-1:0];
          inflight <= inflight_next;
          if (sum_over || enq_orphan || enq_bad_num) begin
            err_overflow <= 1'b1;
          end
        end
        S_FLUSH: begin
          // Packets granted before the redirect drain during these cycles.
          if (flush_cnt == IW'(1)) begin
            state      <= S_RUN;
            flush_cnt  <= '0;
            flush_busy <= 1'b0;
          end else begin
            flush_cnt <= flush_cnt - IW'(1);
          end
        end
        default: begin
          state      <= S_RUN;
          flush_busy <= 1'b0;
        end
      endcase
    end
  end

endmodule
